// File: rtl/gmac_tx_client.sv
// Store-and-forward byte buffer that feeds one EMAC client transmit port.
// Frames are committed only when complete; oversize frames are dropped on the write side.
module gmac_tx_client #(
   parameter int ADDR_WIDTH = 11,
   parameter int MAX_LEN    = 1518
) (
   input  logic                  clk125,
   input  logic                  resetn,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_data_valid,
   input  logic                  tx_ack,
   output logic                  frame_drop,
   output logic [ADDR_WIDTH-1:0] frames_pending
);

   localparam int          DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_FIRST = 2'd1,
      RD_BODY  = 2'd2,
      RD_GAP   = 2'd3
   } rd_state_e;

   logic [8:0]            mem [0:DEPTH-1];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] commit_ptr_q, commit_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]           len_q, len_d;
   logic                  discard_q, discard_d;
   logic                  s_ready_q, s_ready_d;
   logic                  frame_drop_q, frame_drop_d;
   logic [ADDR_WIDTH-1:0] frames_pending_q, frames_pending_d;
   rd_state_e             state_q, state_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [7:0]            tx_data_q;
   logic                  tx_last_q;

   logic                  accept_s;
   logic                  wr_en_s;
   logic                  commit_s;
   logic                  release_s;
   logic                  rd_en_s;
   logic [ADDR_WIDTH-1:0] rd_addr_s;
   logic [ADDR_WIDTH-1:0] wr_next_s;

   assign accept_s = s_valid & s_ready_q;

   // Write side: speculative pointer, frame length, commit and oversize discard
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      len_d        = len_q;
      discard_d    = discard_q;
      frame_drop_d = 1'b0;
      wr_en_s      = 1'b0;
      commit_s     = 1'b0;
      if (accept_s) begin
         if (discard_q) begin
            if (s_last) begin
               discard_d    = 1'b0;
               frame_drop_d = 1'b1;
               len_d        = 16'd0;
            end else begin
               len_d = len_q;
            end
         end else if (len_q == MAX_LEN_C) begin
            // A byte beyond MAX_LEN: throw away everything written for this frame.
            wr_ptr_d = commit_ptr_q;
            len_d    = 16'd0;
            if (s_last) begin
               frame_drop_d = 1'b1;
            end else begin
               discard_d = 1'b1;
            end
         end else begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_last) begin
               commit_ptr_d = wr_ptr_q + PTR_ONE;
               commit_s     = 1'b1;
               len_d        = 16'd0;
            end else begin
               len_d = len_q + 16'd1;
            end
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Read FSM: hold byte 0 until ack, then stream the rest with no holes
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      tx_valid_d = tx_valid_q;
      rd_en_s    = 1'b0;
      rd_addr_s  = rd_ptr_q;
      release_s  = 1'b0;
      case (state_q)
         RD_IDLE: begin
            tx_valid_d = 1'b0;
            if (frames_pending_q != '0) begin
               state_d    = RD_FIRST;
               tx_valid_d = 1'b1;
               rd_en_s    = 1'b1;
            end else begin
               state_d = RD_IDLE;
            end
         end
         RD_FIRST: begin
            tx_valid_d = 1'b1;
            if (tx_ack) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               if (tx_last_q) begin
                  state_d    = RD_GAP;
                  tx_valid_d = 1'b0;
                  release_s  = 1'b1;
               end else begin
                  state_d   = RD_BODY;
                  rd_en_s   = 1'b1;
                  rd_addr_s = rd_ptr_q + PTR_ONE;
               end
            end else begin
               state_d = RD_FIRST;
            end
         end
         RD_BODY: begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (tx_last_q) begin
               state_d    = RD_GAP;
               tx_valid_d = 1'b0;
               release_s  = 1'b1;
            end else begin
               tx_valid_d = 1'b1;
               rd_en_s    = 1'b1;
               rd_addr_s  = rd_ptr_q + PTR_ONE;
            end
         end
         RD_GAP: begin
            if (frames_pending_q != '0) begin
               state_d    = RD_FIRST;
               tx_valid_d = 1'b1;
               rd_en_s    = 1'b1;
            end else begin
               state_d    = RD_IDLE;
               tx_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = RD_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   // Pending-frame count and the registered full flag
   always_comb begin
      case ({commit_s, release_s})
         2'b10:   frames_pending_d = frames_pending_q + PTR_ONE;
         2'b01:   frames_pending_d = frames_pending_q - PTR_ONE;
         default: frames_pending_d = frames_pending_q;
      endcase
      wr_next_s = wr_ptr_d + PTR_ONE;
      // Computed from next-state pointers so the flop matches the current occupancy.
      s_ready_d = discard_d | (wr_next_s != rd_ptr_d);
   end

   // Control and pointer registers
   always_ff @(posedge clk125 or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q         <= '0;
         commit_ptr_q     <= '0;
         rd_ptr_q         <= '0;
         len_q            <= 16'd0;
         discard_q        <= 1'b0;
         s_ready_q        <= 1'b0;
         frame_drop_q     <= 1'b0;
         frames_pending_q <= '0;
         state_q          <= RD_IDLE;
         tx_valid_q       <= 1'b0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         commit_ptr_q     <= commit_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         len_q            <= len_d;
         discard_q        <= discard_d;
         s_ready_q        <= s_ready_d;
         frame_drop_q     <= frame_drop_d;
         frames_pending_q <= frames_pending_d;
         state_q          <= state_d;
         tx_valid_q       <= tx_valid_d;
      end
   end

   // Buffer write port
   always_ff @(posedge clk125) begin
      if (wr_en_s) begin
         mem[wr_ptr_q] <= {s_last, s_data};
      end
   end

   // Registered buffer read doubles as the transmit data register
   always_ff @(posedge clk125 or negedge resetn) begin
      if (!resetn) begin
         tx_data_q <= 8'd0;
         tx_last_q <= 1'b0;
      end else if (rd_en_s) begin
         {tx_last_q, tx_data_q} <= mem[rd_addr_s];
      end
   end

   assign s_ready        = s_ready_q;
   assign tx_data        = tx_data_q;
   assign tx_data_valid  = tx_valid_q;
   assign frame_drop     = frame_drop_q;
   assign frames_pending = frames_pending_q;

endmodule

// File: tb/tb_gmac_tx_client.sv
// Randomized bench for gmac_tx_client: frames go into a reference queue when committed and
// an independent monitor checks EMAC-side timing, data, pending count and drops.
module tb_gmac_tx_client;

   localparam int AW = 11;
   localparam int ML = 1518;
   localparam int P_IDLE = 0, P_FIRST = 1, P_BODY = 2, P_GAP = 3;

   logic          clk125 = 1'b0;
   logic          resetn;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic [7:0]    tx_data;
   logic          tx_data_valid;
   logic          tx_ack;
   logic          frame_drop;
   logic [AW-1:0] frames_pending;

   always #4 clk125 = ~clk125;

   gmac_tx_client #(.ADDR_WIDTH(AW), .MAX_LEN(ML)) dut (
      .clk125(clk125), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .tx_data(tx_data),
      .tx_data_valid(tx_data_valid), .tx_ack(tx_ack), .frame_drop(frame_drop),
      .frames_pending(frames_pending)
   );

   typedef struct {
      int len;
      int acc;
   } frame_t;

   frame_t     exp_q[$];
   logic [7:0] exp_bytes[$];
   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int exp_drops = 0, seen_drops = 0;
   int tot_acc = 0;
   bit ack_en = 1'b1;
   int ack_rate = 2;
   int phase = P_IDLE;
   int idx = 0;
   int cur_len = 0;
   bit cur_active = 1'b0;

   always @(posedge clk125) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string nm, input int act, input int req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
   endtask

   task automatic step();
      @(posedge clk125);
      #1;
   endtask

   // Random ack generator; ack outside byte 0 must be ignored by the DUT.
   initial begin
      tx_ack = 1'b0;
      forever begin
         @(posedge clk125);
         #1;
         tx_ack = ack_en && (ack_rate == 0 || $urandom_range(0, ack_rate) == 0);
      end
   end

   // Monitor: pops the expected stream and checks every cycle of the EMAC side.
   initial begin : monitor
      int mp;
      bit ev;
      frame_t f;
      forever begin
         @(negedge clk125);
         if (!resetn) begin
            phase = P_IDLE;
            cur_active = 1'b0;
         end else begin
            if (frame_drop) seen_drops++;
            mp = cur_active ? 1 : 0;
            foreach (exp_q[i]) if (exp_q[i].acc <= cyc - 1) mp++;
            chk(int'(frames_pending) == mp, "frames_pending", int'(frames_pending), mp);
            if (phase == P_GAP) begin
               chk(!tx_data_valid, "gap_valid_low", int'(tx_data_valid), 0);
               phase = P_IDLE;
            end else if (phase == P_IDLE) begin
               ev = (exp_q.size() > 0) && (exp_q[0].acc <= cyc - 2);
               chk(tx_data_valid == ev, "start_timing", int'(tx_data_valid), int'(ev));
               if (tx_data_valid && exp_q.size() > 0) begin
                  f = exp_q.pop_front();
                  cur_len = f.len;
                  idx = 0;
                  cur_active = 1'b1;
                  phase = P_FIRST;
               end
            end else if (phase == P_BODY) begin
               chk(tx_data_valid && tx_data == exp_bytes[0], "body_byte",
                   tx_data_valid ? int'(tx_data) : -1, int'(exp_bytes[0]));
               void'(exp_bytes.pop_front());
               idx++;
               if (idx == cur_len) begin
                  phase = P_GAP;
                  cur_active = 1'b0;
               end
            end
            if (phase == P_FIRST) begin
               chk(tx_data_valid && tx_data == exp_bytes[0], "first_byte_held",
                   tx_data_valid ? int'(tx_data) : -1, int'(exp_bytes[0]));
               if (tx_ack) begin
                  void'(exp_bytes.pop_front());
                  idx = 1;
                  if (cur_len == 1) begin
                     phase = P_GAP;
                     cur_active = 1'b0;
                  end else begin
                     phase = P_BODY;
                  end
               end
            end
         end
      end
   end

   // Drives one frame with random idle gaps and records what should come out.
   task automatic send_frame(input int len, input int start, input bit rnd);
      logic [7:0] b;
      logic [7:0] bq[$];
      int w;
      frame_t f;
      f.len = len;
      f.acc = 0;
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            s_valid = 1'b0;
            s_last = 1'b0;
            step();
         end
         b = rnd ? 8'($urandom) : 8'(start + i);
         s_valid = 1'b1;
         s_data = b;
         s_last = (i == len - 1);
         w = 0;
         while (!s_ready && w < 20000) begin
            step();
            w++;
         end
         if (w >= 20000) begin
            chk(1'b0, "s_ready_timeout", 0, 1);
            s_valid = 1'b0;
            s_last = 1'b0;
            return;
         end
         tot_acc++;
         bq.push_back(b);
         if (i == len - 1) f.acc = cyc;
         step();
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      if (len <= ML) begin
         exp_q.push_back(f);
         foreach (bq[i]) exp_bytes.push_back(bq[i]);
      end else begin
         exp_drops++;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || phase != P_IDLE) && w < 30000) begin
         @(posedge clk125);
         w++;
      end
      chk(w < 30000, "drain_timeout", w, 30000);
      step();
   endtask

   initial begin : stim
      int start;
      int w;
      int len;
      resetn = 1'b0;
      s_valid = 1'b0;
      s_data = 8'd0;
      s_last = 1'b0;
      repeat (3) @(posedge clk125);
      #1;
      chk(tx_data == 8'd0, "rst_tx_data", int'(tx_data), 0);
      chk(!tx_data_valid, "rst_tx_valid", int'(tx_data_valid), 0);
      chk(!frame_drop, "rst_frame_drop", int'(frame_drop), 0);
      chk(frames_pending == '0, "rst_pending", int'(frames_pending), 0);
      chk(!s_ready, "rst_s_ready", int'(s_ready), 0);
      resetn = 1'b1;
      #1;
      chk(!s_ready, "s_ready_before_edge", int'(s_ready), 0);
      step();
      chk(s_ready, "s_ready_after_edge", int'(s_ready), 1);

      ack_rate = 3;
      send_frame(64, 0, 1'b0);
      drain();
      send_frame(1, 8'hA5, 1'b0);
      drain();

      ack_rate = 0;
      repeat (3) send_frame(60, 0, 1'b1);
      drain();

      ack_rate = 2;
      send_frame(ML + 1, 0, 1'b1);
      chk(frame_drop, "drop_pulse", int'(frame_drop), 1);
      step();
      chk(!frame_drop, "drop_one_cycle", int'(frame_drop), 0);
      send_frame(64, 8'h40, 1'b0);
      send_frame(ML, 0, 1'b1);
      drain();
      chk(seen_drops == 1, "drop_count_oversize", seen_drops, 1);

      // Backpressure: no acks, 1500 + 1500 bytes, buffer must fill at 2047 bytes.
      ack_en = 1'b0;
      start = tot_acc;
      fork
         begin
            send_frame(1500, 0, 1'b1);
            send_frame(1500, 0, 1'b1);
         end
         begin
            w = 0;
            do begin
               @(negedge clk125);
               w++;
            end while (s_ready && w < 20000);
            chk(tot_acc - start == 2047, "full_occupancy", tot_acc - start, 2047);
            repeat (20) @(negedge clk125);
            chk(!s_ready, "stays_full", int'(s_ready), 0);
            ack_en = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a transmitted frame.
      ack_rate = 0;
      send_frame(200, 0, 1'b1);
      w = 0;
      while (phase != P_BODY && w < 5000) begin
         @(negedge clk125);
         w++;
      end
      chk(w < 5000, "reach_body_timeout", w, 5000);
      @(posedge clk125);
      #1;
      resetn = 1'b0;
      #1;
      chk(!tx_data_valid, "midreset_valid", int'(tx_data_valid), 0);
      chk(frames_pending == '0, "midreset_pending", int'(frames_pending), 0);
      exp_q.delete();
      exp_bytes.delete();
      step();
      step();
      resetn = 1'b1;
      step();
      send_frame(64, 0, 1'b0);
      drain();

      // Random mix of lengths including the oversize boundary.
      ack_rate = 2;
      for (int k = 0; k < 40; k++) begin
         if (k % 10 == 5) begin
            case ($urandom_range(0, 3))
               0:       len = ML - 1;
               1:       len = ML;
               2:       len = ML + 1;
               default: len = ML + 5;
            endcase
         end else begin
            len = $urandom_range(1, 100);
         end
         send_frame(len, 0, 1'b1);
      end
      drain();

      chk(seen_drops == exp_drops, "drop_count_total", seen_drops, exp_drops);
      chk(frames_pending == '0, "final_pending", int'(frames_pending), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
